// File: rtl/rtc_pkg.sv
// Shared DS1302 command bytes and the scheduler FSM encoding.
package rtc_pkg;

  typedef enum logic [7:0] {
    CMD_SEC_WR  = 8'h80,
    CMD_SEC_RD  = 8'h81,
    CMD_MIN_WR  = 8'h82,
    CMD_MIN_RD  = 8'h83,
    CMD_HOUR_WR = 8'h84,
    CMD_HOUR_RD = 8'h85
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_PUBLISH
  } state_t;

  // Read command for round index 0/1/2 (seconds, minutes, hours).
  function automatic logic [7:0] rd_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    rd_cmd = CMD_SEC_RD;
      2'd1:    rd_cmd = CMD_MIN_RD;
      default: rd_cmd = CMD_HOUR_RD;
    endcase
  endfunction

endpackage

// File: rtl/rtc_poll_timer.sv
// Free-running poll interval counter; tick marks the wrap from POLL_CYCLES-1 to 0.
module rtc_poll_timer #(
  parameter int unsigned POLL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(POLL_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rtc_poll_sched.sv
// Arbitrates user writes and periodic seconds/minutes/hours read rounds onto a
// single DS1302 serial engine, publishing the three time bytes atomically.
module rtc_poll_sched
  import rtc_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pollEn,
  input  logic       wrReq,
  input  logic [7:0] wrAddr,
  input  logic [7:0] wrData,
  output logic       wrAck,
  output logic       engStart,
  output logic [7:0] engAddr,
  output logic       engWrite,
  output logic [7:0] engWrData,
  input  logic       engDone,
  input  logic [7:0] engRdData,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic       timeValid,
  output logic       busy,
  output logic       err
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [1:0]    idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic          err_q, err_d;
  logic [7:0]    addr_q, addr_d;
  logic          write_q, write_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [2:0][7:0] shadow_q;
  logic [7:0]    sec_q, min_q, hour_q;
  logic          tv_q;
  logic          poll_tick;
  logic          rd_done;
  logic [2:0]    shadow_we;

  rtc_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .en  (pollEn),
    .tick(poll_tick)
  );

  assign rd_done = (state_q == ST_RD_WAIT) && engDone;

  for (genvar gi = 0; gi < 3; gi++) begin : g_shadow_we
    assign shadow_we[gi] = rd_done && (idx_q == 2'(gi));
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    to_d    = to_q;
    err_d   = err_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (wrReq) begin
          state_d = ST_WR_ISSUE;
          addr_d  = wrAddr;
          write_d = 1'b1;
          wdata_d = wrData;
        end else if (pend_q) begin
          state_d = ST_RD_ISSUE;
          idx_d   = 2'd0;
          addr_d  = rd_cmd(2'd0);
          write_d = 1'b0;
          wdata_d = 8'h00;
        end
      end
      ST_WR_ISSUE: begin
        state_d = ST_WR_WAIT;
        to_d    = '0;
      end
      ST_WR_WAIT: begin
        // A timed-out write falls back to IDLE and is reissued while wrReq stays high.
        if (engDone) begin
          state_d = ST_IDLE;
        end else if (to_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_RD_ISSUE: begin
        state_d = ST_RD_WAIT;
        to_d    = '0;
      end
      ST_RD_WAIT: begin
        if (engDone) begin
          if (idx_q == 2'd2) begin
            state_d = ST_PUBLISH;
          end else begin
            state_d = ST_RD_ISSUE;
            idx_d   = idx_q + 2'd1;
            addr_d  = rd_cmd(idx_q + 2'd1);
          end
        end else if (to_q == TO_LAST) begin
          // Abandon the round; the next timer wrap starts a fresh one.
          state_d = ST_IDLE;
          err_d   = 1'b1;
          pend_d  = 1'b0;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      ST_PUBLISH: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // A wrap always leaves one poll pending, even one landing in PUBLISH.
    if (poll_tick) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= 2'd0;
      to_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= 8'h00;
      write_q <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
    end
  end

  // timeValid trails PUBLISH by one cycle so it coincides with the new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      sec_q    <= 8'h00;
      min_q    <= 8'h00;
      hour_q   <= 8'h00;
      tv_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (shadow_we[i]) shadow_q[i] <= engRdData;
      end
      tv_q <= (state_q == ST_PUBLISH);
      if (state_q == ST_PUBLISH) begin
        sec_q  <= shadow_q[0];
        min_q  <= shadow_q[1];
        hour_q <= shadow_q[2];
      end
    end
  end

  assign engStart  = !rst && ((state_q == ST_WR_ISSUE) || (state_q == ST_RD_ISSUE));
  assign wrAck     = !rst && (state_q == ST_WR_WAIT) && engDone;
  assign busy      = !rst && (state_q != ST_IDLE);
  assign engAddr   = addr_q;
  assign engWrite  = write_q;
  assign engWrData = wdata_q;
  assign seconds   = sec_q;
  assign minutes   = min_q;
  assign hours     = hour_q;
  assign timeValid = tv_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rtc_poll_sched.sv
// Directed bench for rtc_poll_sched with a behavioural DS1302 engine model.
module tb_rtc_poll_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pollEn = 1'b0;
  logic       wrReq = 1'b0;
  logic [7:0] wrAddr = 8'h00;
  logic [7:0] wrData = 8'h00;
  logic       wrAck, engStart, engWrite, timeValid, busy, err;
  logic [7:0] engAddr, engWrData, seconds, minutes, hours;
  logic       engDone;
  logic [7:0] engRdData;

  logic       eng_done_m = 1'b0;
  logic [7:0] eng_rd_m = 8'h00;
  logic       stray_done = 1'b0;
  logic [7:0] rd_sec = 8'h00, rd_min = 8'h00, rd_hr = 8'h00;
  int         eng_delay = 0;
  bit         eng_silent = 1'b0;

  assign engDone   = eng_done_m | stray_done;
  assign engRdData = stray_done ? 8'h99 : eng_rd_m;

  always #5 clk = ~clk;

  rtc_poll_sched #(
    .POLL_CYCLES   (20),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pollEn   (pollEn),
    .wrReq    (wrReq),
    .wrAddr   (wrAddr),
    .wrData   (wrData),
    .wrAck    (wrAck),
    .engStart (engStart),
    .engAddr  (engAddr),
    .engWrite (engWrite),
    .engWrData(engWrData),
    .engDone  (engDone),
    .engRdData(engRdData),
    .seconds  (seconds),
    .minutes  (minutes),
    .hours    (hours),
    .timeValid(timeValid),
    .busy     (busy),
    .err      (err)
  );

  // Engine: arms on engStart, answers eng_delay cycles into the wait state.
  bit armed = 1'b0;
  int cnt = 0;
  always begin
    @(negedge clk);
    if (engStart && !eng_silent) begin
      armed = 1'b1;
      cnt   = eng_delay;
    end
    @(posedge clk);
    #2;
    eng_done_m = 1'b0;
    if (eng_silent) begin
      armed = 1'b0;
    end else if (armed) begin
      if (cnt == 0) begin
        eng_done_m = 1'b1;
        armed      = 1'b0;
        case (engAddr)
          8'h81:   eng_rd_m = rd_sec;
          8'h83:   eng_rd_m = rd_min;
          8'h85:   eng_rd_m = rd_hr;
          default: eng_rd_m = 8'h00;
        endcase
      end else begin
        cnt--;
      end
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } txn_t;

  txn_t log_q[$];
  int cyc = 0, tv_cnt = 0, tv_cyc = 0, ack_cnt = 0, ack_cyc = 0;

  always @(negedge clk) begin
    txn_t t;
    cyc++;
    if (engStart) begin
      t.wr = engWrite; t.addr = engAddr; t.data = engWrData; t.cyc = cyc;
      log_q.push_back(t);
      $display("[%0d] txn %s addr=%02h wdata=%02h", cyc, engWrite ? "WR" : "RD", engAddr, engWrData);
    end
    if (timeValid) begin
      tv_cnt++;
      tv_cyc = cyc;
      $display("[%0d] timeValid sec=%02h min=%02h hr=%02h", cyc, seconds, minutes, hours);
    end
    if (wrAck) begin
      ack_cnt++;
      ack_cyc = cyc;
      $display("[%0d] wrAck", cyc);
    end
  end

  int nerr = 0, nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; pollEn = 1'b0; wrReq = 1'b0; eng_silent = 1'b1; stray_done = 1'b0;
    repeat (3) step();
    rst = 1'b0; eng_silent = 1'b0;
    log_q.delete();
  endtask

  // Runs until a timeValid has been seen and any pending write has been acked.
  task automatic run_round(input int bound, input string nm);
    int tv0;
    bit seen, done;
    tv0 = tv_cnt; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      step();
      if (wrReq && wrAck) wrReq = 1'b0;
      if (tv_cnt != tv0) seen = 1'b1;
      if (seen && !wrReq) done = 1'b1;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_start(input logic [7:0] a, input int bound, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      step();
      if (engStart && engAddr == a) hit = 1'b1;
    end
    chk({nm, "_start"}, 32'(hit), 32'd1);
  endtask

  typedef struct {
    logic [7:0] d_sec, d_min, d_hr;
    int         dly;
    logic [7:0] e_sec, e_min, e_hr;
  } rvec_t;

  initial begin
    rvec_t tbl[4];
    logic [7:0] rd_addr[3];
    int tv0, ack0, lat;
    bit busy_seen;

    tbl[0] = '{8'h45, 8'h12, 8'h09, 0, 8'h45, 8'h12, 8'h09};
    tbl[1] = '{8'h59, 8'h59, 8'h23, 1, 8'h59, 8'h59, 8'h23};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h00, 8'h00};
    tbl[3] = '{8'h07, 8'h30, 8'h12, 2, 8'h07, 8'h30, 8'h12};
    rd_addr[0] = 8'h81; rd_addr[1] = 8'h83; rd_addr[2] = 8'h85;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_seconds", 32'(seconds), 32'h00);
    chk("rst_minutes", 32'(minutes), 32'h00);
    chk("rst_hours", 32'(hours), 32'h00);
    chk("rst_engAddr", 32'(engAddr), 32'h00);
    chk("rst_engWrData", 32'(engWrData), 32'h00);
    chk("rst_engStart", 32'(engStart), 32'd0);
    chk("rst_engWrite", 32'(engWrite), 32'd0);
    chk("rst_wrAck", 32'(wrAck), 32'd0);
    chk("rst_timeValid", 32'(timeValid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // Table of poll rounds with varying engine latency
    pollEn = 1'b1;
    foreach (tbl[v]) begin
      rd_sec = tbl[v].d_sec; rd_min = tbl[v].d_min; rd_hr = tbl[v].d_hr;
      eng_delay = tbl[v].dly;
      log_q.delete();
      tv0 = tv_cnt;
      run_round(200, $sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d_tvcount", v), 32'(tv_cnt - tv0), 32'd1);
      chk($sformatf("tbl%0d_ntxn", v), 32'(log_q.size()), 32'd3);
      if (log_q.size() >= 3) begin
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("tbl%0d_addr%0d", v, k), 32'(log_q[k].addr), 32'(rd_addr[k]));
          chk($sformatf("tbl%0d_wr%0d", v, k), 32'(log_q[k].wr), 32'd0);
        end
        lat = tv_cyc - log_q[0].cyc;
        chk($sformatf("tbl%0d_latency", v), 32'(lat), 32'(3 * (tbl[v].dly + 2) + 1));
      end
      chk($sformatf("tbl%0d_seconds", v), 32'(seconds), 32'(tbl[v].e_sec));
      chk($sformatf("tbl%0d_minutes", v), 32'(minutes), 32'(tbl[v].e_min));
      chk($sformatf("tbl%0d_hours", v), 32'(hours), 32'(tbl[v].e_hr));
    end

    // Write and pollPend arrive together: write goes first
    do_reset();
    rd_sec = 8'h59; rd_min = 8'h30; rd_hr = 8'h23; eng_delay = 0;
    pollEn = 1'b1;
    repeat (20) step();
    wrAddr = 8'h80; wrData = 8'h30; wrReq = 1'b1;
    tv0 = tv_cnt; ack0 = ack_cnt;
    run_round(300, "prio");
    chk("prio_ack", 32'(ack_cnt - ack0), 32'd1);
    chk("prio_tv", 32'(tv_cnt - tv0), 32'd1);
    chk("prio_ntxn", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 4) begin
      chk("prio_first_wr", 32'(log_q[0].wr), 32'd1);
      chk("prio_first_addr", 32'(log_q[0].addr), 32'h80);
      chk("prio_first_data", 32'(log_q[0].data), 32'h30);
      chk("prio_second_addr", 32'(log_q[1].addr), 32'h81);
    end
    chk("prio_ack_before_tv", 32'(ack_cyc < tv_cyc), 32'd1);
    chk("prio_seconds", 32'(seconds), 32'h59);

    // Write raised during the minutes read waits for the round to publish
    do_reset();
    rd_sec = 8'h11; rd_min = 8'h22; rd_hr = 8'h03; eng_delay = 2;
    pollEn = 1'b1;
    wait_start(8'h83, 100, "midwr");
    wrAddr = 8'h82; wrData = 8'h17; wrReq = 1'b1;
    ack0 = ack_cnt;
    run_round(300, "midwr");
    pollEn = 1'b0;
    chk("midwr_ack", 32'(ack_cnt - ack0), 32'd1);
    chk("midwr_ntxn", 32'(log_q.size()), 32'd4);
    if (log_q.size() >= 4) begin
      chk("midwr_wr", 32'(log_q[3].wr), 32'd1);
      chk("midwr_addr", 32'(log_q[3].addr), 32'h82);
      chk("midwr_data", 32'(log_q[3].data), 32'h17);
      chk("midwr_after_tv", 32'(log_q[3].cyc > tv_cyc), 32'd1);
    end
    chk("midwr_minutes", 32'(minutes), 32'h22);

    // Engine stops answering: err after 16 wait cycles, outputs held
    do_reset();
    rd_sec = 8'h33; rd_min = 8'h44; rd_hr = 8'h05; eng_delay = 0;
    pollEn = 1'b1;
    run_round(200, "to_pre");
    eng_silent = 1'b1;
    wait_start(8'h81, 100, "to");
    tv0 = tv_cnt;
    repeat (16) step();
    chk("to_err_early", 32'(err), 32'd0);
    step();
    chk("to_err_set", 32'(err), 32'd1);
    repeat (60) step();
    chk("to_no_tv", 32'(tv_cnt - tv0), 32'd0);
    chk("to_seconds", 32'(seconds), 32'h33);
    chk("to_minutes", 32'(minutes), 32'h44);
    chk("to_hours", 32'(hours), 32'h05);
    rd_sec = 8'h21; rd_min = 8'h43; rd_hr = 8'h06;
    eng_silent = 1'b0;
    run_round(200, "to_recover");
    chk("to_recover_seconds", 32'(seconds), 32'h21);
    chk("to_err_sticky", 32'(err), 32'd1);

    // Reset in RD_WAIT at index 1, then a stray engDone
    do_reset();
    rd_sec = 8'h48; rd_min = 8'h27; rd_hr = 8'h13; eng_delay = 3;
    pollEn = 1'b1;
    run_round(200, "rstmid_pre");
    wait_start(8'h83, 100, "rstmid");
    step();
    eng_silent = 1'b1; rst = 1'b1;
    tv0 = tv_cnt; ack0 = ack_cnt;
    step();
    chk("rstmid_seconds", 32'(seconds), 32'h00);
    chk("rstmid_minutes", 32'(minutes), 32'h00);
    chk("rstmid_hours", 32'(hours), 32'h00);
    chk("rstmid_engAddr", 32'(engAddr), 32'h00);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_engStart", 32'(engStart), 32'd0);
    rst = 1'b0; eng_silent = 1'b0;
    repeat (2) step();
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    repeat (5) step();
    chk("stray_no_tv", 32'(tv_cnt - tv0), 32'd0);
    chk("stray_no_ack", 32'(ack_cnt - ack0), 32'd0);
    chk("stray_seconds", 32'(seconds), 32'h00);
    chk("stray_busy", 32'(busy), 32'd0);

    // Polling disabled for 100 cycles
    do_reset();
    busy_seen = 1'b0;
    repeat (100) begin
      step();
      busy_seen |= busy;
    end
    chk("idle_no_start", 32'(log_q.size()), 32'd0);
    chk("idle_busy", 32'(busy_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", nchk, nerr);
    $fatal(1, "watchdog expired");
  end

endmodule
